// File: rtl/proc_fetch_buffer.sv
// Instruction-fetch front end. It issues imem requests for the datapath PC and
// tracks outstanding requests with a credit scheme. Responses that belong to
// squashed fetches are discarded. Live responses go into a small in-order
// FIFO, which feeds the decode stage through a val/rdy handshake.
module proc_fetch_buffer #(
   parameter int p_max_inflight = 2,
   parameter int p_buf_entries  = 2
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                fetch_val,
   output logic                                fetch_rdy,
   input  logic [31:0]                         fetch_addr,
   input  logic                                squash,
   output logic                                imemreq_val,
   input  logic                                imemreq_rdy,
   output logic [31:0]                         imemreq_msg_addr,
   input  logic                                imemresp_val,
   output logic                                imemresp_rdy,
   input  logic [31:0]                         imemresp_data,
   output logic                                inst_val,
   input  logic                                inst_rdy,
   output logic [31:0]                         inst_data,
   output logic [$clog2(p_max_inflight+1)-1:0] inflight_cnt
);

   localparam int CW = $clog2(p_max_inflight + 1);
   localparam int OW = $clog2(p_buf_entries + 1);
   localparam int PW = (p_buf_entries > 1) ? $clog2(p_buf_entries) : 1;
   localparam logic [31:0] MAX_INF = 32'(p_max_inflight);
   localparam logic [31:0] MAX_BUF = 32'(p_buf_entries);
   localparam logic [PW-1:0] LAST_PTR = PW'(p_buf_entries - 1);

   // Control state: outstanding requests, the doomed part of them, FIFO bookkeeping
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop_cnt;
   logic [OW-1:0] occ;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   // Instruction storage (data only, never reset)
   logic [31:0]   mem [p_buf_entries];

   logic [31:0]   live_w;
   logic          credit_ok;
   logic          req_fire;
   logic          resp_fire;
   logic          resp_drop;
   logic          enq;
   logic          pop;

   // Pointer increment that wraps at the FIFO depth, which may not be a power of two
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == LAST_PTR) return '0;
      else               return p + PW'(1);
   endfunction

   // Credit check, handshakes and FIFO head presentation.
   // Every handshake output is gated by reset so it drops as soon as reset asserts.
   always_comb begin
      live_w           = 32'(inflight) - 32'(drop_cnt);
      credit_ok        = (32'(inflight) < MAX_INF) && ((live_w + 32'(occ)) < MAX_BUF);
      imemreq_val      = !reset && fetch_val && credit_ok;
      fetch_rdy        = !reset && imemreq_rdy && credit_ok;
      req_fire         = fetch_val && fetch_rdy;
      imemreq_msg_addr = fetch_addr;
      imemresp_rdy     = !reset;
      resp_fire        = imemresp_val && imemresp_rdy;
      // A response that arrives during a squash is older than the redirect
      resp_drop        = (drop_cnt != '0) || squash;
      enq              = resp_fire && !resp_drop;
      inst_val         = !reset && (occ != '0) && !squash;
      inst_data        = mem[head];
      pop              = inst_val && inst_rdy;
      inflight_cnt     = inflight;
   end

   // Control state update. A squash flushes the FIFO and dooms every request
   // still outstanding after this cycle's response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= '0;
         drop_cnt <= '0;
         occ      <= '0;
         head     <= '0;
         tail     <= '0;
      end else begin
         inflight <= inflight + CW'(req_fire) - CW'(resp_fire);
         if (squash)
            drop_cnt <= inflight - CW'(resp_fire);
         else if (resp_fire && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CW'(1);
         if (squash) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
         end else begin
            if (enq) tail <= next_ptr(tail);
            if (pop) head <= next_ptr(head);
            occ <= occ + OW'(enq) - OW'(pop);
         end
      end
   end

   // Write accepted instruction words at the tail
   always_ff @(posedge clk) begin
      if (enq) mem[tail] <= imemresp_data;
   end

   // Protocol checks: no response without an outstanding request, and no enqueue into a full FIFO
   a_resp_without_req: assert property (@(posedge clk) disable iff (reset)
      !(resp_fire && (inflight == '0)));
   a_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
      !(enq && !pop && (32'(occ) == MAX_BUF)));

endmodule

// File: tb/tb_proc_fetch_buffer.sv
// Bench for proc_fetch_buffer: a cycle table of directed vectors, reset
// sequences, and a randomized-latency streaming run against a PC model.
module tb_proc_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_val;
   logic        fetch_rdy;
   logic [31:0] fetch_addr;
   logic        squash;
   logic        imemreq_val;
   logic        imemreq_rdy;
   logic [31:0] imemreq_msg_addr;
   logic        imemresp_val;
   logic        imemresp_rdy;
   logic [31:0] imemresp_data;
   logic        inst_val;
   logic        inst_rdy;
   logic [31:0] inst_data;
   logic [1:0]  inflight_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   proc_fetch_buffer #(.p_max_inflight(2), .p_buf_entries(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .fetch_val        (fetch_val),
      .fetch_rdy        (fetch_rdy),
      .fetch_addr       (fetch_addr),
      .squash           (squash),
      .imemreq_val      (imemreq_val),
      .imemreq_rdy      (imemreq_rdy),
      .imemreq_msg_addr (imemreq_msg_addr),
      .imemresp_val     (imemresp_val),
      .imemresp_rdy     (imemresp_rdy),
      .imemresp_data    (imemresp_data),
      .inst_val         (inst_val),
      .inst_rdy         (inst_rdy),
      .inst_data        (inst_data),
      .inflight_cnt     (inflight_cnt)
   );

   typedef struct {
      logic        fv;
      logic [31:0] addr;
      logic        sq;
      logic        mrdy;
      logic        rv;
      logic [31:0] rdata;
      logic        irdy;
      logic        e_frdy;
      logic        e_mval;
      logic        e_ival;
      logic [31:0] e_idata;
      logic [1:0]  e_infl;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } resp_t;

   vec_t        vecs[$];
   resp_t       memq[$];
   logic [31:0] expq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic fv, input logic [31:0] addr, input logic sq, input logic mrdy,
                      input logic rv, input logic [31:0] rdata, input logic irdy,
                      input logic e_frdy, input logic e_mval, input logic e_ival,
                      input logic [31:0] e_idata, input logic [1:0] e_infl);
      vec_t v;
      v.fv = fv; v.addr = addr; v.sq = sq; v.mrdy = mrdy; v.rv = rv; v.rdata = rdata;
      v.irdy = irdy; v.e_frdy = e_frdy; v.e_mval = e_mval; v.e_ival = e_ival;
      v.e_idata = e_idata; v.e_infl = e_infl;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          cyc;
      int          fired;
      int          popped;
      int          due;
      logic [31:0] pc;

      // streaming with 1-cycle imem
      add(1, 32'h200, 0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2'd0);
      add(1, 32'h204, 0, 1, 1, 32'h00000013, 1, 1, 1, 0, 32'h0,        2'd1);
      add(1, 32'h208, 0, 1, 1, 32'h00100093, 1, 0, 0, 1, 32'h00000013, 2'd1);
      add(1, 32'h208, 0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h00100093, 2'd0);
      add(0, 32'h20C, 0, 1, 1, 32'h00200113, 1, 1, 0, 0, 32'h0,        2'd1);
      add(0, 32'h20C, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'h00200113, 2'd0);
      // backpressure: FIFO fills, fetch stalls, drain resumes fetch
      add(1, 32'h400, 0, 1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        2'd0);
      add(1, 32'h404, 0, 1, 1, 32'hAAAA0000, 0, 1, 1, 0, 32'h0,        2'd1);
      add(1, 32'h408, 0, 1, 1, 32'hAAAA0001, 0, 0, 0, 1, 32'hAAAA0000, 2'd1);
      add(1, 32'h408, 0, 1, 0, 32'h0,        0, 0, 0, 1, 32'hAAAA0000, 2'd0);
      add(1, 32'h408, 0, 1, 0, 32'h0,        1, 0, 0, 1, 32'hAAAA0000, 2'd0);
      add(1, 32'h408, 0, 1, 0, 32'h0,        1, 1, 1, 1, 32'hAAAA0001, 2'd0);
      add(0, 32'h40C, 0, 1, 1, 32'hAAAA0002, 1, 1, 0, 0, 32'h0,        2'd1);
      add(0, 32'h40C, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'hAAAA0002, 2'd0);
      // squash with two in flight, redirect to 0x300
      add(1, 32'h500, 0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2'd0);
      add(1, 32'h504, 0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2'd1);
      add(1, 32'h300, 1, 1, 0, 32'h0,        1, 0, 0, 0, 32'h0,        2'd2);
      add(1, 32'h300, 0, 1, 1, 32'hDEAD0000, 1, 0, 0, 0, 32'h0,        2'd2);
      add(1, 32'h300, 0, 1, 1, 32'hDEAD0001, 1, 1, 1, 0, 32'h0,        2'd1);
      add(0, 32'h304, 0, 1, 1, 32'h00500293, 1, 1, 0, 0, 32'h0,        2'd1);
      add(0, 32'h304, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'h00500293, 2'd0);
      // squash coincident with a response and inst_rdy=1, one inst buffered
      add(1, 32'h600, 0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2'd0);
      add(1, 32'h604, 0, 1, 1, 32'hBBBB0000, 0, 1, 1, 0, 32'h0,        2'd1);
      add(1, 32'h700, 1, 1, 1, 32'hBBBB0001, 1, 0, 0, 0, 32'h0,        2'd1);
      add(1, 32'h700, 0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2'd0);
      add(0, 32'h704, 0, 1, 1, 32'hCCCC0000, 1, 1, 0, 0, 32'h0,        2'd1);
      add(0, 32'h704, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'hCCCC0000, 2'd0);
      // squash while a redirect request fires the same cycle: that request stays live
      add(1, 32'h900, 0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2'd0);
      add(1, 32'h800, 1, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2'd1);
      add(0, 32'h804, 0, 1, 1, 32'hDEAD0002, 1, 0, 0, 0, 32'h0,        2'd2);
      add(0, 32'h804, 0, 1, 1, 32'hDDDD0000, 1, 1, 0, 0, 32'h0,        2'd1);
      add(0, 32'h804, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'hDDDD0000, 2'd0);
      // imem not ready: request is offered but does not fire
      add(1, 32'hA00, 0, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        2'd0);
      add(0, 32'hA00, 0, 1, 0, 32'h0,        1, 1, 0, 0, 32'h0,        2'd0);

      // reset state, with requests offered so the gating is visible
      reset = 1'b1; fetch_val = 1'b1; fetch_addr = 32'h100; squash = 1'b0;
      imemreq_rdy = 1'b1; imemresp_val = 1'b0; imemresp_data = 32'h0; inst_rdy = 1'b1;
      #2;
      check("rst fetch_rdy", 32'(fetch_rdy), 32'd0);
      check("rst imemreq_val", 32'(imemreq_val), 32'd0);
      check("rst imemresp_rdy", 32'(imemresp_rdy), 32'd0);
      check("rst inst_val", 32'(inst_val), 32'd0);
      check("rst inflight", 32'(inflight_cnt), 32'd0);
      @(negedge clk); @(negedge clk);
      fetch_val = 1'b0; reset = 1'b0;

      // cycle table
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         fetch_val = vecs[i].fv; fetch_addr = vecs[i].addr; squash = vecs[i].sq;
         imemreq_rdy = vecs[i].mrdy; imemresp_val = vecs[i].rv;
         imemresp_data = vecs[i].rdata; inst_rdy = vecs[i].irdy;
         #1;
         check($sformatf("v%0d fetch_rdy", i), 32'(fetch_rdy), 32'(vecs[i].e_frdy));
         check($sformatf("v%0d imemreq_val", i), 32'(imemreq_val), 32'(vecs[i].e_mval));
         check($sformatf("v%0d req_addr", i), imemreq_msg_addr, vecs[i].addr);
         check($sformatf("v%0d inst_val", i), 32'(inst_val), 32'(vecs[i].e_ival));
         check($sformatf("v%0d inflight", i), 32'(inflight_cnt), 32'(vecs[i].e_infl));
         if (vecs[i].e_ival)
            check($sformatf("v%0d inst_data", i), inst_data, vecs[i].e_idata);
      end

      // reset mid-stream with one request outstanding and one inst buffered
      @(negedge clk);
      fetch_val = 1'b1; fetch_addr = 32'hB00; squash = 1'b0; imemreq_rdy = 1'b1;
      imemresp_val = 1'b0; inst_rdy = 1'b0;
      @(negedge clk);
      fetch_addr = 32'hB04; imemresp_val = 1'b1; imemresp_data = 32'h11110001;
      @(negedge clk);
      fetch_val = 1'b0; imemresp_val = 1'b0;
      #1;
      check("pre-rst inst_val", 32'(inst_val), 32'd1);
      check("pre-rst inflight", 32'(inflight_cnt), 32'd1);
      #1;
      reset = 1'b1; fetch_val = 1'b1;
      #1;
      check("mid-rst inst_val", 32'(inst_val), 32'd0);
      check("mid-rst imemreq_val", 32'(imemreq_val), 32'd0);
      check("mid-rst fetch_rdy", 32'(fetch_rdy), 32'd0);
      check("mid-rst inflight", 32'(inflight_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0; fetch_val = 1'b0; inst_rdy = 1'b1;
      #1;
      check("post-rst inflight", 32'(inflight_cnt), 32'd0);
      check("post-rst inst_val", 32'(inst_val), 32'd0);
      check("post-rst fetch_rdy", 32'(fetch_rdy), 32'd1);
      check("post-rst imemresp_rdy", 32'(imemresp_rdy), 32'd1);
      @(negedge clk);
      #1;
      check("post-rst fifo empty", 32'(inst_val), 32'd0);

      // random imem latency and random inst_rdy over 1000 fetches
      cyc = 0; fired = 0; popped = 0; pc = 32'h1000;
      while ((fired < 1000 || popped < fired) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         fetch_val   = (fired < 1000) && ($urandom_range(0, 3) != 0);
         fetch_addr  = pc;
         squash      = 1'b0;
         imemreq_rdy = ($urandom_range(0, 4) != 0);
         inst_rdy    = ($urandom_range(0, 2) != 0);
         if (memq.size() > 0 && memq[0].due <= cyc) begin
            imemresp_val  = 1'b1;
            imemresp_data = memq[0].data;
            void'(memq.pop_front());
         end else begin
            imemresp_val = 1'b0;
         end
         #1;
         if (inflight_cnt > 2'd2)
            check("rand inflight bound", 32'(inflight_cnt), 32'd2);
         if (fetch_val && fetch_rdy) begin
            check("rand req_addr", imemreq_msg_addr, pc);
            due = cyc + 1 + int'($urandom_range(0, 4));
            if (memq.size() > 0 && due < memq[memq.size()-1].due)
               due = memq[memq.size()-1].due;
            memq.push_back('{data: word_of(pc), due: due});
            expq.push_back(word_of(pc));
            pc = pc + 32'd4;
            fired++;
         end
         if (inst_val && inst_rdy) begin
            if (expq.size() == 0)
               check("rand spurious inst", inst_data, 32'hFFFFFFFF);
            else
               check("rand inst_data", inst_data, expq.pop_front());
            popped++;
         end
      end
      check("rand fetched", 32'(fired), 32'd1000);
      check("rand delivered", 32'(popped), 32'd1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
